// File: rtl/sica_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sica_window_sequencer
// Description : Front-end controller for sica_top. Collects one analysis
//               window of whitened samples arriving sample-interleaved
//               (s0c0, s0c1 .. s0c(DIM-1), s1c0, ...) over a valid/ready
//               stream, stores it channel-major, then replays it in address
//               order to sica_top while holding sica_start. Waits for
//               sica_complete under a timeout and rearms for the next window.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1           clock, rising edge
//   nreset         in   1           asynchronous reset, active low
//   enable         in   1           1 = process windows continuously
//   abort          in   1           synchronous abort back to IDLE
//   in_data        in   DATA_WIDTH  input sample, sample-interleaved order
//   in_valid       in   1           in_data valid
//   in_ready       out  1           buffer accepting data (FILL only)
//   serial_z_in    out  DATA_WIDTH  word replayed to sica_top
//   serial_z_valid out  1           serial_z_in valid
//   load_data      out  1           load phase active
//   sica_start     out  1           start level to sica_top (PRIME..RUN)
//   sica_complete  in   1           completion from sica_top
//   window_done    out  1           one-cycle pulse per completed window
//   window_count   out  16          completed windows, wraps
//   timeout_err    out  1           sticky timeout flag
//   busy           out  1           state != IDLE
// ============================================================================
module sica_window_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int DIM            = 5,
  parameter int SAMPLES        = 1024,
  parameter int ADDR_WIDTH     = 13,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  enable,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] serial_z_in,
  output logic                  serial_z_valid,
  output logic                  load_data,
  output logic                  sica_start,
  input  logic                  sica_complete,
  output logic                  window_done,
  output logic [15:0]           window_count,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam int                    c_N         = DIM * SAMPLES;
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(c_N - 1);
  localparam logic [ADDR_WIDTH-1:0] c_LAST_CH   = ADDR_WIDTH'(DIM - 1);
  localparam logic [ADDR_WIDTH-1:0] c_LAST_SMP  = ADDR_WIDTH'(SAMPLES - 1);
  localparam logic [ADDR_WIDTH-1:0] c_STRIDE    = ADDR_WIDTH'(SAMPLES);
  localparam logic [31:0]           c_TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_PRIME = 3'd2,
    S_LOAD  = 3'd3,
    S_RUN   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Window buffer: one write port (FILL), one synchronous read port (replay)
  logic [DATA_WIDTH-1:0] r_mem [0:c_N-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write-side position. r_wr_addr tracks c*SAMPLES+s incrementally: stepping
  // the channel adds one stride, wrapping the channel restarts at s+1.
  logic [ADDR_WIDTH-1:0] r_ch;
  logic [ADDR_WIDTH-1:0] r_smp;
  logic [ADDR_WIDTH-1:0] r_wr_addr;

  logic [ADDR_WIDTH-1:0] r_ld_cnt;      // LOAD cycle index 0..N-1
  logic [31:0]           r_to_cnt;      // RUN cycles elapsed
  logic                  r_window_done;
  logic [15:0]           r_window_count;
  logic                  r_timeout_err;

  logic                  w_accept;
  logic                  w_last_word;
  logic                  w_rd_en;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_complete_hit;
  logic                  w_timeout_hit;
  logic                  w_in_ready;
  logic                  w_load;
  logic                  w_start;
  logic                  w_busy;

  // --------------------------------------------------------------------------
  // Next-state and decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_in_ready     = 1'b0;
    w_load         = 1'b0;
    w_start        = 1'b0;
    w_busy         = (r_state != S_IDLE);
    w_accept       = 1'b0;
    w_last_word    = (r_ch == c_LAST_CH) && (r_smp == c_LAST_SMP);
    w_rd_en        = 1'b0;
    w_rd_addr      = '0;
    w_complete_hit = 1'b0;
    w_timeout_hit  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        w_in_ready = 1'b1;
        w_accept   = in_valid;
        if (in_valid && w_last_word) w_state_nxt = S_PRIME;
      end
      S_PRIME: begin
        // Read of address 0 issued here so word 0 is on the bus in LOAD cycle 0
        w_start     = 1'b1;
        w_rd_en     = 1'b1;
        w_rd_addr   = '0;
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        // Each LOAD cycle prefetches the word shown in the following cycle
        w_start   = 1'b1;
        w_load    = 1'b1;
        w_rd_en   = (r_ld_cnt != c_LAST_ADDR);
        w_rd_addr = r_ld_cnt + 1'b1;
        if (r_ld_cnt == c_LAST_ADDR) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_start = 1'b1;
        // Completion beats a timeout landing in the same cycle
        if (sica_complete) begin
          w_complete_hit = 1'b1;
          w_state_nxt    = enable ? S_FILL : S_IDLE;
        end else if (r_to_cnt == c_TO_LAST) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = S_ERR;
        end
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides every transition and suppresses any event this cycle
    if (abort) begin
      w_state_nxt    = S_IDLE;
      w_accept       = 1'b0;
      w_complete_hit = 1'b0;
      w_timeout_hit  = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State and control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state        <= S_IDLE;
      r_ch           <= '0;
      r_smp          <= '0;
      r_wr_addr      <= '0;
      r_ld_cnt       <= '0;
      r_to_cnt       <= '0;
      r_window_done  <= 1'b0;
      r_window_count <= '0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      // Fill position is held at zero outside FILL, which also discards a
      // partially filled window on abort.
      if ((r_state != S_FILL) || abort) begin
        r_ch      <= '0;
        r_smp     <= '0;
        r_wr_addr <= '0;
      end else if (w_accept) begin
        if (r_ch == c_LAST_CH) begin
          r_ch      <= '0;
          r_smp     <= r_smp + 1'b1;
          r_wr_addr <= r_smp + 1'b1;
        end else begin
          r_ch      <= r_ch + 1'b1;
          r_wr_addr <= r_wr_addr + c_STRIDE;
        end
      end

      if ((r_state == S_LOAD) && !abort) r_ld_cnt <= r_ld_cnt + 1'b1;
      else                               r_ld_cnt <= '0;

      if ((r_state == S_RUN) && !abort) r_to_cnt <= r_to_cnt + 1'b1;
      else                              r_to_cnt <= '0;

      r_window_done <= w_complete_hit;

      if (w_complete_hit) r_window_count <= r_window_count + 1'b1;

      if (abort)              r_timeout_err <= 1'b0;
      else if (w_timeout_hit) r_timeout_err <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Buffer write port (contents need no reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_addr] <= in_data;
  end

  // Read register doubles as serial_z_in: it only updates on reads, so the
  // last replayed word stays on the bus once LOAD finishes.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_rd_data <= '0;
    end else if (abort) begin
      r_rd_data <= '0;
    end else if (w_rd_en) begin
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready       = w_in_ready;
  assign serial_z_in    = r_rd_data;
  assign serial_z_valid = w_load;
  assign load_data      = w_load;
  assign sica_start     = w_start;
  assign window_done    = r_window_done;
  assign window_count   = r_window_count;
  assign timeout_err    = r_timeout_err;
  assign busy           = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_sica_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sica_window_sequencer
// Description : Directed self-checking bench for sica_window_sequencer with
//               DIM=2, SAMPLES=4, TIMEOUT_CYCLES=20.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sica_window_sequencer;

  localparam int c_DW  = 32;
  localparam int c_DIM = 2;
  localparam int c_SMP = 4;
  localparam int c_AW  = 3;
  localparam int c_TO  = 20;

  logic            clk;
  logic            nreset;
  logic            enable;
  logic            abort;
  logic [c_DW-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [c_DW-1:0] serial_z_in;
  logic            serial_z_valid;
  logic            load_data;
  logic            sica_start;
  logic            sica_complete;
  logic            window_done;
  logic [15:0]     window_count;
  logic            timeout_err;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Replay order offsets for a window fed as base+0..base+7 (hand transposed)
  int ord [8]     = '{0, 2, 4, 6, 1, 3, 5, 7};
  int gap_pat [8] = '{1, 0, 2, 0, 0, 3, 1, 1};

  sica_window_sequencer #(
    .DATA_WIDTH     (c_DW),
    .DIM            (c_DIM),
    .SAMPLES        (c_SMP),
    .ADDR_WIDTH     (c_AW),
    .TIMEOUT_CYCLES (c_TO)
  ) u_dut (
    .clk            (clk),
    .nreset         (nreset),
    .enable         (enable),
    .abort          (abort),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .serial_z_in    (serial_z_in),
    .serial_z_valid (serial_z_valid),
    .load_data      (load_data),
    .sica_start     (sica_start),
    .sica_complete  (sica_complete),
    .window_done    (window_done),
    .window_count   (window_count),
    .timeout_err    (timeout_err),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, got time %0t want < 200000", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive nwords samples base..base+nwords-1, optionally with idle gaps.
  // Returns just after the edge that accepted the last word.
  task automatic fill(input int base, input int nwords, input bit gaps);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 10) begin
      step();
      guard++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_ready_wait got in_ready=%b want 1", in_ready);
    end
    for (int i = 0; i < nwords; i++) begin
      if (gaps) begin
        repeat (gap_pat[i]) begin
          in_valid = 1'b0;
          in_data  = 32'hBAD0_0000;
          step();
        end
      end
      in_valid = 1'b1;
      in_data  = c_DW'(base + i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({in_ready, serial_z_valid, load_data, sica_start, window_done, timeout_err, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000000",
               {in_ready, serial_z_valid, load_data, sica_start, window_done, timeout_err, busy});
    end
    n_checks++;
    if (serial_z_in !== 32'd0 || window_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_data got z=%0d cnt=%0d want 0 0", serial_z_in, window_count);
    end
    repeat (2) @(posedge clk);
    #3;
    nreset = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_enable got busy=%b want 0", busy);
    end
    enable = 1'b1;
    abort  = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_abort_blocks got busy=%b want 0", busy);
    end
    abort = 1'b0;
  endtask

  task automatic test_transpose();
    fill(1, 8, 1'b0);
    n_checks++;
    if (sica_start !== 1'b1 || in_ready !== 1'b0 || load_data !== 1'b0) begin
      n_fail++;
      $display("FAIL tr_prime got start=%b rdy=%b load=%b want 1 0 0", sica_start, in_ready, load_data);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (load_data !== 1'b1 || serial_z_valid !== 1'b1 || serial_z_in !== c_DW'(1 + ord[k])) begin
        n_fail++;
        $display("FAIL tr_word%0d got load=%b vld=%b z=%0d want 1 1 %0d",
                 k, load_data, serial_z_valid, serial_z_in, 1 + ord[k]);
      end
    end
    step();
    n_checks++;
    if (load_data !== 1'b0 || serial_z_valid !== 1'b0 || sica_start !== 1'b1 || serial_z_in !== 32'd8) begin
      n_fail++;
      $display("FAIL tr_run_entry got load=%b vld=%b start=%b z=%0d want 0 0 1 8",
               load_data, serial_z_valid, sica_start, serial_z_in);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_gaps();
    fill(1, 8, 1'b1);
    // in_valid held high with junk while not in FILL must be ignored
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    n_checks++;
    if (in_ready !== 1'b0 || sica_start !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_prime got rdy=%b start=%b want 0 1", in_ready, sica_start);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (load_data !== 1'b1 || in_ready !== 1'b0 || serial_z_in !== c_DW'(1 + ord[k])) begin
        n_fail++;
        $display("FAIL gap_word%0d got load=%b rdy=%b z=%0d want 1 0 %0d",
                 k, load_data, in_ready, serial_z_in, 1 + ord[k]);
      end
    end
    step();
    n_checks++;
    if (in_ready !== 1'b0 || load_data !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_run got rdy=%b load=%b want 0 0", in_ready, load_data);
    end
    in_valid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_complete();
    step();
    // completion outside RUN is ignored
    sica_complete = 1'b1;
    step();
    sica_complete = 1'b0;
    n_checks++;
    if (window_done !== 1'b0 || window_count !== 16'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cpl_ignored got done=%b cnt=%0d rdy=%b want 0 0 1", window_done, window_count, in_ready);
    end
    fill(1, 8, 1'b0);
    repeat (9) step();
    n_checks++;
    if (window_done !== 1'b0 || sica_start !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL cpl_run got done=%b start=%b rdy=%b want 0 1 0", window_done, sica_start, in_ready);
    end
    repeat (4) step();
    sica_complete = 1'b1;
    step();
    sica_complete = 1'b0;
    n_checks++;
    if (window_done !== 1'b1 || window_count !== 16'd1 || sica_start !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cpl_first got done=%b cnt=%0d start=%b rdy=%b want 1 1 0 1",
               window_done, window_count, sica_start, in_ready);
    end
    step();
    n_checks++;
    if (window_done !== 1'b0 || window_count !== 16'd1) begin
      n_fail++;
      $display("FAIL cpl_pulse got done=%b cnt=%0d want 0 1", window_done, window_count);
    end
    // second window; enable dropped during LOAD returns to IDLE afterwards
    fill(41, 8, 1'b0);
    step();
    enable = 1'b0;
    repeat (8) step();
    n_checks++;
    if (busy !== 1'b1 || sica_start !== 1'b1 || load_data !== 1'b0) begin
      n_fail++;
      $display("FAIL cpl2_run got busy=%b start=%b load=%b want 1 1 0", busy, sica_start, load_data);
    end
    repeat (4) step();
    sica_complete = 1'b1;
    step();
    sica_complete = 1'b0;
    n_checks++;
    if (window_done !== 1'b1 || window_count !== 16'd2 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL cpl_second got done=%b cnt=%0d busy=%b rdy=%b want 1 2 0 0",
               window_done, window_count, busy, in_ready);
    end
  endtask

  task automatic test_complete_vs_timeout();
    enable = 1'b1;
    fill(51, 8, 1'b0);
    repeat (9) step();
    repeat (19) step();
    n_checks++;
    if (timeout_err !== 1'b0 || sica_start !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_run20 got err=%b start=%b want 0 1", timeout_err, sica_start);
    end
    sica_complete = 1'b1;
    step();
    sica_complete = 1'b0;
    n_checks++;
    if (window_done !== 1'b1 || timeout_err !== 1'b0 || window_count !== 16'd3 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_complete got done=%b err=%b cnt=%0d rdy=%b want 1 0 3 1",
               window_done, timeout_err, window_count, in_ready);
    end
  endtask

  task automatic test_timeout();
    fill(61, 8, 1'b0);
    repeat (9) step();
    repeat (19) step();
    n_checks++;
    if (timeout_err !== 1'b0 || sica_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL to_run20 got err=%b start=%b busy=%b want 0 1 1", timeout_err, sica_start, busy);
    end
    step();
    n_checks++;
    if (timeout_err !== 1'b1 || sica_start !== 1'b0 || in_ready !== 1'b0 || load_data !== 1'b0 ||
        busy !== 1'b1 || window_done !== 1'b0) begin
      n_fail++;
      $display("FAIL to_err got err=%b start=%b rdy=%b load=%b busy=%b done=%b want 1 0 0 0 1 0",
               timeout_err, sica_start, in_ready, load_data, busy, window_done);
    end
    sica_complete = 1'b1;
    in_valid      = 1'b1;
    repeat (3) step();
    sica_complete = 1'b0;
    in_valid      = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b1 || window_count !== 16'd3 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL to_sticky got err=%b busy=%b cnt=%0d rdy=%b want 1 1 3 0",
               timeout_err, busy, window_count, in_ready);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b0 || window_count !== 16'd3) begin
      n_fail++;
      $display("FAIL to_abort got err=%b busy=%b cnt=%0d want 0 0 3", timeout_err, busy, window_count);
    end
  endtask

  task automatic test_abort();
    // partial window then abort: must be discarded
    fill(100, 3, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ab_fill got busy=%b rdy=%b want 0 0", busy, in_ready);
    end
    fill(21, 8, 1'b0);
    repeat (3) step();
    n_checks++;
    if (load_data !== 1'b1 || serial_z_in !== 32'd25) begin
      n_fail++;
      $display("FAIL ab_word3 got load=%b z=%0d want 1 25", load_data, serial_z_in);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if (load_data !== 1'b0 || serial_z_valid !== 1'b0 || sica_start !== 1'b0 || busy !== 1'b0 ||
        serial_z_in !== 32'd0 || window_count !== 16'd3) begin
      n_fail++;
      $display("FAIL ab_load got load=%b vld=%b start=%b busy=%b z=%0d cnt=%0d want 0 0 0 0 0 3",
               load_data, serial_z_valid, sica_start, busy, serial_z_in, window_count);
    end
    fill(9, 8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (load_data !== 1'b1 || serial_z_in !== c_DW'(9 + ord[k])) begin
        n_fail++;
        $display("FAIL ab_fresh%0d got load=%b z=%0d want 1 %0d", k, load_data, serial_z_in, 9 + ord[k]);
      end
    end
    step();
  endtask

  task automatic test_async_reset();
    repeat (2) step();
    n_checks++;
    if (busy !== 1'b1 || sica_start !== 1'b1 || window_count !== 16'd3) begin
      n_fail++;
      $display("FAIL ar_pre got busy=%b start=%b cnt=%0d want 1 1 3", busy, sica_start, window_count);
    end
    #2;
    nreset = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, serial_z_valid, load_data, sica_start, window_done, timeout_err, busy} !== 7'b0 ||
        serial_z_in !== 32'd0 || window_count !== 16'd0) begin
      n_fail++;
      $display("FAIL ar_now got flags=%b z=%0d cnt=%0d want 0000000 0 0",
               {in_ready, serial_z_valid, load_data, sica_start, window_done, timeout_err, busy},
               serial_z_in, window_count);
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || window_count !== 16'd0) begin
      n_fail++;
      $display("FAIL ar_hold got busy=%b cnt=%0d want 0 0", busy, window_count);
    end
    #3;
    nreset = 1'b1;
  endtask

  initial begin
    nreset        = 1'b0;
    enable        = 1'b0;
    abort         = 1'b0;
    in_data       = '0;
    in_valid      = 1'b0;
    sica_complete = 1'b0;

    test_reset();
    test_transpose();
    test_gaps();
    test_complete();
    test_complete_vs_timeout();
    test_timeout();
    test_abort();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
